game_sequencer: RTL and testbench
=================================

// Module: game_sequencer
// PURPOSE
//  Top-level game-flow controller for the breakout physics datapath (ball, board, bricks).
//  Sequences serve / play / pause / life-lost / game-over / win, and generates the physics step strobe.
//  Also issues the ball/board re-position pulse and tracks lives, bricks remaining and score.
//  Sits between the button inputs and the physics controller; its outputs also drive the display/HUD.
// PARAMETERS
//  TICK_DIV     833333  clk cycles per physics step (60 Hz at 50 MHz); must be >= 2
//  SERVE_TICKS  60      tick-periods spent in SERVE before the ball is released; must be >= 1
//  LOST_TICKS   90      tick-periods spent in LOST before re-serve or OVER; must be >= 1
//  NUM_BRICKS   32      brick count per game; 1..63
//  LIVES        3       lives at game start; 1..3
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  start_btn    in   1   start/restart level (already synchronised and debounced)
//  pause_btn    in   1   pause toggle level (already synchronised and debounced)
//  brick_hit    in   1   1-cycle pulse from physics: one brick destroyed
//  ball_lost    in   1   1-cycle pulse from physics: ball reached screen bottom
//  phys_tick    out  1   1-cycle strobe: advance ball/board by one step
//  phys_reset   out  1   1-cycle pulse: re-centre ball and board
//  bricks_reset out  1   1-cycle pulse: revive all bricks
//  state        out  3   0 IDLE, 1 SERVE, 2 PLAY, 3 PAUSED, 4 LOST, 5 OVER, 6 WIN
//  lives        out  2   lives remaining
//  bricks_left  out  6   bricks still alive
//  score        out  16  bricks destroyed this game; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async): state=IDLE, lives=LIVES, bricks_left=NUM_BRICKS, score=0, all pulses 0.
//    Prescaler and dwell counters clear to 0; button edge registers clear to 0.
//  Button handling:
//    start_btn and pause_btn are rising-edge detected internally.
//    An edge is acted on in the cycle after the input goes high; a held level never re-triggers.
//  Prescaler:
//    Counts 0..TICK_DIV-1 and free-runs in every state.
//    The internal tick is high for the cycle the count wraps to 0.
//    phys_tick = internal tick AND state==PLAY; it is never high in any other state.
//  Start edge from IDLE, OVER or WIN:
//    Next cycle: lives=LIVES, bricks_left=NUM_BRICKS, score=0.
//    phys_reset and bricks_reset each pulse once; state -> SERVE; dwell counter cleared.
//  SERVE:
//    Counts internal ticks; on tick number SERVE_TICKS -> PLAY.
//    Pause edge is ignored; start edge is ignored.
//  PLAY:
//    brick_hit: bricks_left-1 and score+1 (score saturates); bricks_left never underflows below 0.
//      If bricks_left goes 1->0 -> WIN.
//    ball_lost (when not winning): lives-1 and state -> LOST; dwell counter cleared.
//    Pause edge -> PAUSED.
//  Simultaneous events in PLAY:
//    brick_hit and ball_lost in the same cycle: the brick is counted first.
//    If that brick empties the field -> WIN and lives is not decremented; otherwise LOST.
//    Pause edge in the same cycle as brick_hit/ball_lost: the event wins and the pause edge is dropped.
//  PAUSED:
//    Pause edge -> PLAY.
//    brick_hit/ball_lost are ignored (physics is frozen).
//    The prescaler keeps running, so the resume phase is arbitrary.
//  LOST:
//    On tick number LOST_TICKS: lives==0 -> OVER; else phys_reset pulses and state -> SERVE.
//  OVER / WIN:
//    Hold all counters; only a start edge leaves (re-init as above).
//  Illegal state encodings 7: next state is IDLE.
//  Outputs are registered; phys_reset and bricks_reset are exactly 1 clk wide.
// TESTING (bench uses TICK_DIV=4, SERVE_TICKS=2, LOST_TICKS=2, NUM_BRICKS=3, LIVES=2)
//  Reset then start pulse -> phys_reset=1 and bricks_reset=1 for 1 clk; state=1.
//    Then state=2 after 2 internal ticks; phys_tick every 4th clk thereafter.
//  In PLAY, 3 brick_hit pulses -> bricks_left 3,2,1,0; score=3; state=6; phys_tick stays 0.
//  2x ball_lost, each followed by LOST dwell:
//    First -> lives=1, state 4->1->2.
//    Second -> lives=0, state 4->5; start then restores lives=2, score=0.
//  brick_hit and ball_lost same cycle with bricks_left=1 -> state=6, lives unchanged.
//    With bricks_left=2 -> state=4, bricks_left=1, lives-1.
//  Pause edge in PLAY -> state=3, no phys_tick for 20 clks, brick_hit ignored.
//    Second pause edge -> state=2; pause held high 10 clks causes only one toggle.
//  Assert reset mid-LOST and mid-PLAY -> same cycle state=0, lives=2, bricks_left=3, score=0.

Source files
------------

// File: rtl/game_sequencer.sv
// game_sequencer: game-flow controller for the breakout physics datapath.
// Sequences serve/play/pause/life-lost/game-over/win and generates the
// physics step strobe. It also issues re-position pulses and tracks lives,
// bricks remaining and score. All outputs come straight from flops.
module game_sequencer #(
  parameter int TICK_DIV    = 833333,
  parameter int SERVE_TICKS = 60,
  parameter int LOST_TICKS  = 90,
  parameter int NUM_BRICKS  = 32,
  parameter int LIVES       = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_btn,
  input  logic        pause_btn,
  input  logic        brick_hit,
  input  logic        ball_lost,
  output logic        phys_tick,
  output logic        phys_reset,
  output logic        bricks_reset,
  output logic [2:0]  state,
  output logic [1:0]  lives,
  output logic [5:0]  bricks_left,
  output logic [15:0] score
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SERVE  = 3'd1;
  localparam logic [2:0] ST_PLAY   = 3'd2;
  localparam logic [2:0] ST_PAUSED = 3'd3;
  localparam logic [2:0] ST_LOST   = 3'd4;
  localparam logic [2:0] ST_OVER   = 3'd5;
  localparam logic [2:0] ST_WIN    = 3'd6;

  localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  localparam int DWELL_MAX = (SERVE_TICKS > LOST_TICKS) ? SERVE_TICKS : LOST_TICKS;
  localparam int DWELL_W   = $clog2(DWELL_MAX + 1);
  localparam logic [DWELL_W-1:0] SERVE_LAST = DWELL_W'(SERVE_TICKS - 1);
  localparam logic [DWELL_W-1:0] LOST_LAST  = DWELL_W'(LOST_TICKS - 1);

  localparam logic [1:0] LIVES_INIT  = 2'(LIVES);
  localparam logic [5:0] BRICKS_INIT = 6'(NUM_BRICKS);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               start_prev_q, pause_prev_q;
  logic [2:0]         state_q, state_d;
  logic [1:0]         lives_q, lives_d;
  logic [5:0]         bricks_q, bricks_d;
  logic [15:0]        score_q, score_d;
  logic               phys_tick_q, phys_tick_d;
  logic               phys_reset_q, phys_reset_d;
  logic               bricks_reset_q, bricks_reset_d;

  logic tick_s;
  logic start_edge_s;
  logic pause_edge_s;
  logic hit_ok_s;
  logic won_s;

  // Free-running prescaler; the tick marks the cycle the count wraps.
  always_comb begin
    tick_s = (cnt_q == CNT_LAST);
    if (tick_s) begin
      cnt_d = {CNT_W{1'b0}};
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Button rising edges and brick-event qualification for this cycle.
  always_comb begin
    start_edge_s = start_btn & ~start_prev_q;
    pause_edge_s = pause_btn & ~pause_prev_q;
    hit_ok_s     = brick_hit & (bricks_q != 6'd0);
    won_s        = hit_ok_s & (bricks_q == 6'd1);
  end

  // Game-flow state machine together with the lives/bricks/score bookkeeping.
  always_comb begin
    state_d        = state_q;
    lives_d        = lives_q;
    bricks_d       = bricks_q;
    score_d        = score_q;
    dwell_d        = dwell_q;
    phys_reset_d   = 1'b0;
    bricks_reset_d = 1'b0;

    case (state_q)
      ST_IDLE, ST_OVER, ST_WIN: begin
        if (start_edge_s) begin
          lives_d        = LIVES_INIT;
          bricks_d       = BRICKS_INIT;
          score_d        = 16'd0;
          dwell_d        = {DWELL_W{1'b0}};
          phys_reset_d   = 1'b1;
          bricks_reset_d = 1'b1;
          state_d        = ST_SERVE;
        end else begin
          state_d = state_q;
        end
      end

      ST_SERVE: begin
        if (tick_s) begin
          if (dwell_q == SERVE_LAST) begin
            dwell_d = {DWELL_W{1'b0}};
            state_d = ST_PLAY;
          end else begin
            dwell_d = dwell_q + DWELL_W'(1);
          end
        end else begin
          dwell_d = dwell_q;
        end
      end

      ST_PLAY: begin
        // The brick is always counted first so a field-clearing hit wins
        // over a simultaneous ball loss.
        if (hit_ok_s) begin
          bricks_d = bricks_q - 6'd1;
          score_d  = (score_q == 16'hFFFF) ? score_q : (score_q + 16'd1);
        end else begin
          bricks_d = bricks_q;
        end

        if (won_s) begin
          state_d = ST_WIN;
        end else if (ball_lost) begin
          lives_d = (lives_q != 2'd0) ? (lives_q - 2'd1) : 2'd0;
          dwell_d = {DWELL_W{1'b0}};
          state_d = ST_LOST;
        end else if (pause_edge_s && !brick_hit) begin
          state_d = ST_PAUSED;
        end else begin
          state_d = ST_PLAY;
        end
      end

      ST_PAUSED: begin
        if (pause_edge_s) begin
          state_d = ST_PLAY;
        end else begin
          state_d = ST_PAUSED;
        end
      end

      ST_LOST: begin
        if (tick_s) begin
          if (dwell_q == LOST_LAST) begin
            dwell_d = {DWELL_W{1'b0}};
            if (lives_q == 2'd0) begin
              state_d = ST_OVER;
            end else begin
              phys_reset_d = 1'b1;
              state_d      = ST_SERVE;
            end
          end else begin
            dwell_d = dwell_q + DWELL_W'(1);
          end
        end else begin
          dwell_d = dwell_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Qualify with the next state so the registered strobe is only ever
    // seen together with state == PLAY.
    phys_tick_d = tick_s & (state_d == ST_PLAY);
  end

  // State, counters and registered outputs; asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q          <= {CNT_W{1'b0}};
      dwell_q        <= {DWELL_W{1'b0}};
      start_prev_q   <= 1'b0;
      pause_prev_q   <= 1'b0;
      state_q        <= ST_IDLE;
      lives_q        <= LIVES_INIT;
      bricks_q       <= BRICKS_INIT;
      score_q        <= 16'd0;
      phys_tick_q    <= 1'b0;
      phys_reset_q   <= 1'b0;
      bricks_reset_q <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      dwell_q        <= dwell_d;
      start_prev_q   <= start_btn;
      pause_prev_q   <= pause_btn;
      state_q        <= state_d;
      lives_q        <= lives_d;
      bricks_q       <= bricks_d;
      score_q        <= score_d;
      phys_tick_q    <= phys_tick_d;
      phys_reset_q   <= phys_reset_d;
      bricks_reset_q <= bricks_reset_d;
    end
  end

  assign phys_tick    = phys_tick_q;
  assign phys_reset   = phys_reset_q;
  assign bricks_reset = bricks_reset_q;
  assign state        = state_q;
  assign lives        = lives_q;
  assign bricks_left  = bricks_q;
  assign score        = score_q;

endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed stimulus with a cycle-level behavioural model
// of the game rules, compared against the DUT on every falling clock edge,
// plus hand-computed literal expectations at key points of the game.
module tb_game_sequencer;

  localparam int TICK_DIV    = 4;
  localparam int SERVE_TICKS = 2;
  localparam int LOST_TICKS  = 2;
  localparam int NUM_BRICKS  = 3;
  localparam int LIVES       = 2;

  localparam int S_IDLE = 0, S_SERVE = 1, S_PLAY = 2, S_PAUSED = 3,
                 S_LOST = 4, S_OVER = 5, S_WIN = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_btn = 1'b0;
  logic        pause_btn = 1'b0;
  logic        brick_hit = 1'b0;
  logic        ball_lost = 1'b0;
  logic        phys_tick, phys_reset, bricks_reset;
  logic [2:0]  state;
  logic [1:0]  lives;
  logic [5:0]  bricks_left;
  logic [15:0] score;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  game_sequencer #(
    .TICK_DIV(TICK_DIV), .SERVE_TICKS(SERVE_TICKS), .LOST_TICKS(LOST_TICKS),
    .NUM_BRICKS(NUM_BRICKS), .LIVES(LIVES)
  ) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .pause_btn(pause_btn),
    .brick_hit(brick_hit), .ball_lost(ball_lost), .phys_tick(phys_tick),
    .phys_reset(phys_reset), .bricks_reset(bricks_reset), .state(state),
    .lives(lives), .bricks_left(bricks_left), .score(score)
  );

  // 10-unit clock.
  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model of the game rules ----------------
  int m_state, m_lives, m_bricks, m_score, m_cycle, m_ticks_seen, m_next;
  bit m_ptick, m_preset, m_breset, m_prev_start, m_prev_pause;
  bit m_tick, m_sedge, m_pedge, m_won;

  // Model advances on each rising edge, or resets asynchronously.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_state = S_IDLE; m_lives = LIVES; m_bricks = NUM_BRICKS; m_score = 0;
      m_cycle = 0; m_ticks_seen = 0; m_ptick = 0; m_preset = 0; m_breset = 0;
      m_prev_start = 0; m_prev_pause = 0;
    end else begin
      // A step tick happens every TICK_DIV-th cycle counted from reset.
      m_tick  = ((m_cycle % TICK_DIV) == TICK_DIV - 1);
      m_sedge = start_btn && !m_prev_start;
      m_pedge = pause_btn && !m_prev_pause;
      m_preset = 0; m_breset = 0; m_won = 0;
      m_next = m_state;
      if (m_state == S_IDLE || m_state == S_OVER || m_state == S_WIN) begin
        if (m_sedge) begin
          m_lives = LIVES; m_bricks = NUM_BRICKS; m_score = 0;
          m_preset = 1; m_breset = 1; m_ticks_seen = 0; m_next = S_SERVE;
        end
      end else if (m_state == S_SERVE) begin
        if (m_tick) m_ticks_seen++;
        if (m_ticks_seen == SERVE_TICKS) begin m_next = S_PLAY; m_ticks_seen = 0; end
      end else if (m_state == S_PLAY) begin
        if (brick_hit && m_bricks > 0) begin
          m_bricks--;
          if (m_score < 65535) m_score++;
          if (m_bricks == 0) begin m_won = 1; m_next = S_WIN; end
        end
        if (!m_won && ball_lost) begin
          m_lives = (m_lives > 0) ? m_lives - 1 : 0;
          m_next = S_LOST; m_ticks_seen = 0;
        end else if (!m_won && !brick_hit && m_pedge) begin
          m_next = S_PAUSED;
        end
      end else if (m_state == S_PAUSED) begin
        if (m_pedge) m_next = S_PLAY;
      end else if (m_state == S_LOST) begin
        if (m_tick) m_ticks_seen++;
        if (m_ticks_seen == LOST_TICKS) begin
          m_ticks_seen = 0;
          if (m_lives == 0) m_next = S_OVER;
          else begin m_next = S_SERVE; m_preset = 1; end
        end
      end else begin
        m_next = S_IDLE;
      end
      m_ptick = m_tick && (m_next == S_PLAY);
      m_state = m_next;
      m_cycle++;
      m_prev_start = start_btn;
      m_prev_pause = pause_btn;
    end
  end

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_state", int'(state), m_state);
      check("m_lives", int'(lives), m_lives);
      check("m_bricks", int'(bricks_left), m_bricks);
      check("m_score", int'(score), m_score);
      check("m_phys_tick", int'(phys_tick), int'(m_ptick));
      check("m_phys_reset", int'(phys_reset), int'(m_preset));
      check("m_bricks_reset", int'(bricks_reset), int'(m_breset));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic press_start();
    @(negedge clk); start_btn = 1'b1;
    @(negedge clk); start_btn = 1'b0;
  endtask

  task automatic pulse(input bit hit, input bit lost, input bit pz);
    @(negedge clk); brick_hit = hit; ball_lost = lost; pause_btn = pz;
    @(negedge clk); brick_hit = 1'b0; ball_lost = 1'b0; pause_btn = 1'b0;
  endtask

  task automatic wait_state(input string name, input int s, input int budget);
    int n = 0;
    while (int'(state) != s && n < budget) begin
      @(negedge clk); n++;
    end
    check(name, int'(state), s);
  endtask

  task automatic count_ticks(input int cycles, output int ones);
    ones = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (phys_tick) ones++;
    end
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_state"}, int'(state), S_IDLE);
    check({name, "_lives"}, int'(lives), 2);
    check({name, "_bricks"}, int'(bricks_left), 3);
    check({name, "_score"}, int'(score), 0);
    check({name, "_pulses"}, int'({phys_tick, phys_reset, bricks_reset}), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int ones;
    #1 reset = 1'b1;
    #2 check_reset_vals("rst");
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // First game: serve, tick period, clear the field.
    @(negedge clk); start_btn = 1'b1;
    @(negedge clk);
    check("start_state", int'(state), S_SERVE);
    check("start_phys_reset", int'(phys_reset), 1);
    check("start_bricks_reset", int'(bricks_reset), 1);
    @(negedge clk);
    check("phys_reset_1clk", int'(phys_reset), 0);
    check("bricks_reset_1clk", int'(bricks_reset), 0);
    start_btn = 1'b0;
    wait_state("to_play", S_PLAY, 3 * TICK_DIV);

    n = 0;
    while (!phys_tick && n < 2 * TICK_DIV) begin @(negedge clk); n++; end
    check("first_tick_seen", int'(phys_tick), 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!phys_tick && n < 3 * TICK_DIV);
    check("tick_period", n, 4);

    pulse(1'b1, 1'b0, 1'b0); check("hit1_bricks", int'(bricks_left), 2);
    pulse(1'b1, 1'b0, 1'b0); check("hit2_bricks", int'(bricks_left), 1);
    pulse(1'b1, 1'b0, 1'b0); check("hit3_bricks", int'(bricks_left), 0);
    check("win_score", int'(score), 3);
    check("win_state", int'(state), S_WIN);
    count_ticks(12, ones);
    check("win_no_tick", ones, 0);

    // Second game: two lost balls lead to OVER, restart re-initialises.
    press_start();
    wait_state("g2_play", S_PLAY, 3 * TICK_DIV);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    check("lost1_state", int'(state), S_LOST);
    check("lost1_lives", int'(lives), 1);
    wait_state("lost1_serve", S_SERVE, 3 * TICK_DIV);
    wait_state("lost1_play", S_PLAY, 3 * TICK_DIV);
    pulse(1'b0, 1'b1, 1'b0);
    check("lost2_state", int'(state), S_LOST);
    check("lost2_lives", int'(lives), 0);
    wait_state("over", S_OVER, 3 * TICK_DIV);
    check("over_score", int'(score), 1);
    press_start();
    check("restart_lives", int'(lives), 2);
    check("restart_score", int'(score), 0);
    check("restart_bricks", int'(bricks_left), 3);

    // Simultaneous brick_hit and ball_lost.
    wait_state("g3_play", S_PLAY, 3 * TICK_DIV);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b1, 1'b0);
    check("both2_state", int'(state), S_LOST);
    check("both2_bricks", int'(bricks_left), 1);
    check("both2_lives", int'(lives), 1);
    wait_state("both_play", S_PLAY, 6 * TICK_DIV);
    pulse(1'b1, 1'b1, 1'b0);
    check("both1_state", int'(state), S_WIN);
    check("both1_lives", int'(lives), 1);

    // Pause: held level toggles once, physics frozen.
    press_start();
    wait_state("g4_play", S_PLAY, 3 * TICK_DIV);
    @(negedge clk); pause_btn = 1'b1;
    ones = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (phys_tick) ones++;
      if (i == 9) check("pause_held_state", int'(state), S_PAUSED);
    end
    pause_btn = 1'b0;
    brick_hit = 1'b1;
    @(negedge clk); brick_hit = 1'b0;
    if (phys_tick) ones++;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (phys_tick) ones++;
    end
    check("paused_no_tick", ones, 0);
    check("paused_bricks", int'(bricks_left), 3);
    @(negedge clk); pause_btn = 1'b1;
    repeat (10) @(negedge clk);
    check("resume_state", int'(state), S_PLAY);
    pause_btn = 1'b0;
    pulse(1'b1, 1'b0, 1'b1);
    check("pause_hit_state", int'(state), S_PLAY);
    check("pause_hit_bricks", int'(bricks_left), 2);

    // Asynchronous reset mid-PLAY and mid-LOST.
    @(negedge clk); #2 reset = 1'b1;
    #1 check_reset_vals("rst_play");
    @(negedge clk); reset = 1'b0;
    press_start();
    wait_state("g5_play", S_PLAY, 3 * TICK_DIV);
    pulse(1'b0, 1'b1, 1'b0);
    check("g5_lost", int'(state), S_LOST);
    @(negedge clk); #2 reset = 1'b1;
    #1 check_reset_vals("rst_lost");
    @(negedge clk); reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
